// File: rtl/not_gate_bist_checker.sv
// Built-in self-test engine for an N-bit inverter bank. It sweeps every input
// pattern, checks each settled response against the bitwise complement and reports the result.
module not_gate_bist_checker #(
  parameter int WIDTH       = 4,
  parameter int SETTLE      = 2,
  parameter int ERR_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             err_valid,
  output logic [WIDTH-1:0] first_err_pattern,
  output logic [WIDTH-1:0] first_err_value
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] LAST_PAT    = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] settle_cnt_r;

  logic compare_s;
  logic mismatch_s;
  logic last_s;
  logic stop_s;
  logic finish_s;

  // Case-equality makes an X or Z response count as a failure in simulation.
  function automatic logic pattern_matches(input logic [WIDTH-1:0] pat,
                                           input logic [WIDTH-1:0] obs);
    return (obs === ~pat);
  endfunction

  // Compare-edge decode: which event, if any, this edge carries.
  always_comb begin
    compare_s  = 1'b0;
    mismatch_s = 1'b0;
    last_s     = 1'b0;
    stop_s     = 1'b0;
    finish_s   = 1'b0;
    if (state_r == RUN) begin
      compare_s  = (settle_cnt_r == {CNT_W{1'b0}});
      mismatch_s = compare_s && !pattern_matches(dut_in, dut_out);
      last_s     = compare_s && (dut_in == LAST_PAT);
      stop_s     = mismatch_s && (STOP_ON_ERR != 0);
      finish_s   = abort || last_s || stop_s;
    end else begin
      compare_s  = 1'b0;
    end
  end

  // Sweep FSM with all result outputs held in registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r           <= IDLE;
      settle_cnt_r      <= {CNT_W{1'b0}};
      dut_in            <= {WIDTH{1'b0}};
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      err_count         <= {ERR_W{1'b0}};
      err_valid         <= 1'b0;
      first_err_pattern <= {WIDTH{1'b0}};
      first_err_value   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r           <= RUN;
            settle_cnt_r      <= SETTLE_LOAD;
            dut_in            <= {WIDTH{1'b0}};
            busy              <= 1'b1;
            done              <= 1'b0;
            pass              <= 1'b0;
            err_count         <= {ERR_W{1'b0}};
            err_valid         <= 1'b0;
            first_err_pattern <= {WIDTH{1'b0}};
            first_err_value   <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          if (compare_s) begin
            settle_cnt_r <= SETTLE_LOAD;
            if (mismatch_s) begin
              if (err_count != ERR_MAX) begin
                err_count <= err_count + ERR_W'(1);
              end
              if (!err_valid) begin
                err_valid         <= 1'b1;
                first_err_pattern <= dut_in;
                first_err_value   <= dut_out;
              end
            end
            // The pattern that ends the run stays on the bank afterwards.
            if (!finish_s) begin
              dut_in <= dut_in + WIDTH'(1);
            end
          end else begin
            settle_cnt_r <= settle_cnt_r - CNT_W'(1);
          end
          if (finish_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= !(abort || stop_s || err_valid || mismatch_s);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_not_gate_bist_checker.sv
// Directed bench for not_gate_bist_checker: a default instance with a switchable
// inverter model, a stop-on-error instance and a narrow-counter saturation instance.
module tb_not_gate_bist_checker;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic start_m = 1'b0, abort_m = 1'b0;
  logic start_s = 1'b0, abort_s = 1'b0;
  logic start_t = 1'b0, abort_t = 1'b0;
  logic [1:0] mode_m = 2'd0;
  int total = 0;
  int bad = 0;

  logic [3:0] din_m, dout_m, fpat_m, fval_m;
  logic       busy_m, done_m, pass_m, ev_m;
  logic [7:0] cnt_m;
  logic [3:0] din_s, dout_s, fpat_s, fval_s;
  logic       busy_s, done_s, pass_s, ev_s;
  logic [7:0] cnt_s;
  logic [3:0] din_t, dout_t, fpat_t, fval_t;
  logic       busy_t, done_t, pass_t, ev_t;
  logic [1:0] cnt_t;

  always #5 clk = ~clk;

  // 0: good inverter, 1: bit 0 stuck at 1, 2: output tied low
  assign dout_m = (mode_m == 2'd0) ? ~din_m :
                  (mode_m == 2'd1) ? (~din_m | 4'h1) : 4'h0;
  assign dout_s = ~din_s | 4'h1;
  assign dout_t = 4'h0;

  not_gate_bist_checker u_main (
    .clk(clk), .reset_L(reset_L), .start(start_m), .abort(abort_m),
    .dut_in(din_m), .dut_out(dout_m), .busy(busy_m), .done(done_m), .pass(pass_m),
    .err_count(cnt_m), .err_valid(ev_m), .first_err_pattern(fpat_m), .first_err_value(fval_m)
  );

  not_gate_bist_checker #(.STOP_ON_ERR(1)) u_stop (
    .clk(clk), .reset_L(reset_L), .start(start_s), .abort(abort_s),
    .dut_in(din_s), .dut_out(dout_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(cnt_s), .err_valid(ev_s), .first_err_pattern(fpat_s), .first_err_value(fval_s)
  );

  not_gate_bist_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .reset_L(reset_L), .start(start_t), .abort(abort_t),
    .dut_in(din_t), .dut_out(dout_t), .busy(busy_t), .done(done_t), .pass(pass_t),
    .err_count(cnt_t), .err_valid(ev_t), .first_err_pattern(fpat_t), .first_err_value(fval_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_m), 32'd0);
    chk({tag, "_done"}, 32'(done_m), 32'd0);
    chk({tag, "_pass"}, 32'(pass_m), 32'd0);
    chk({tag, "_cnt"},  32'(cnt_m),  32'd0);
    chk({tag, "_ev"},   32'(ev_m),   32'd0);
    chk({tag, "_fpat"}, 32'(fpat_m), 32'd0);
    chk({tag, "_fval"}, 32'(fval_m), 32'd0);
    chk({tag, "_din"},  32'(din_m),  32'd0);
  endtask

  initial begin
    // reset state
    #12;
    chk_main_zero("rst");
    tick();
    reset_L = 1'b1;
    tick();

    // good inverter, with an ignored start at e0+6
    mode_m = 2'd0;
    start_m = 1'b1; tick(); start_m = 1'b0;            // e0
    chk("good_e0_busy", 32'(busy_m), 32'd1);
    chk("good_e0_din",  32'(din_m),  32'd0);
    tick(); tick();                                     // e0+2
    chk("good_e2_din",  32'(din_m),  32'd1);
    repeat (3) tick();                                  // e0+5
    start_m = 1'b1; tick(); start_m = 1'b0;            // e0+6
    chk("ign_start_din",  32'(din_m),  32'd3);
    chk("ign_start_busy", 32'(busy_m), 32'd1);
    repeat (25) tick();                                 // e0+31
    chk("good_e31_done", 32'(done_m), 32'd0);
    chk("good_e31_busy", 32'(busy_m), 32'd1);
    tick();                                             // e0+32
    chk("good_done", 32'(done_m), 32'd1);
    chk("good_pass", 32'(pass_m), 32'd1);
    chk("good_busy", 32'(busy_m), 32'd0);
    chk("good_cnt",  32'(cnt_m),  32'd0);
    chk("good_ev",   32'(ev_m),   32'd0);
    chk("good_din",  32'(din_m),  32'hF);
    tick();
    chk("good_sticky_done", 32'(done_m), 32'd1);
    chk("good_sticky_din",  32'(din_m),  32'hF);

    // bit 0 stuck at 1, run to completion
    mode_m = 2'd1;
    start_m = 1'b1; tick(); start_m = 1'b0;            // e0
    chk("sa1_e0_done", 32'(done_m), 32'd0);
    chk("sa1_e0_pass", 32'(pass_m), 32'd0);
    repeat (2) tick();                                  // e0+2
    chk("sa1_e2_cnt", 32'(cnt_m), 32'd0);
    repeat (2) tick();                                  // e0+4
    chk("sa1_e4_cnt",  32'(cnt_m),  32'd1);
    chk("sa1_e4_fpat", 32'(fpat_m), 32'h1);
    repeat (28) tick();                                 // e0+32
    chk("sa1_done", 32'(done_m), 32'd1);
    chk("sa1_pass", 32'(pass_m), 32'd0);
    chk("sa1_cnt",  32'(cnt_m),  32'd8);
    chk("sa1_ev",   32'(ev_m),   32'd1);
    chk("sa1_fpat", 32'(fpat_m), 32'h1);
    chk("sa1_fval", 32'(fval_m), 32'hF);

    // start together with abort from DONE: start wins and results clear
    mode_m = 2'd0;
    start_m = 1'b1; abort_m = 1'b1; tick(); start_m = 1'b0; abort_m = 1'b0;
    chk("clr_busy", 32'(busy_m), 32'd1);
    chk("clr_done", 32'(done_m), 32'd0);
    chk("clr_cnt",  32'(cnt_m),  32'd0);
    chk("clr_ev",   32'(ev_m),   32'd0);
    chk("clr_fpat", 32'(fpat_m), 32'd0);
    chk("clr_fval", 32'(fval_m), 32'd0);
    chk("clr_din",  32'(din_m),  32'd0);
    repeat (4) tick();                                  // e0+4
    abort_m = 1'b1; tick(); abort_m = 1'b0;            // e0+5
    chk("abort_done", 32'(done_m), 32'd1);
    chk("abort_pass", 32'(pass_m), 32'd0);
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_din",  32'(din_m),  32'd2);
    abort_m = 1'b1; tick(); abort_m = 1'b0;
    chk("abort_in_done_done", 32'(done_m), 32'd1);
    chk("abort_in_done_busy", 32'(busy_m), 32'd0);

    // asynchronous reset mid-sweep
    start_m = 1'b1; tick(); start_m = 1'b0;            // e0
    repeat (7) tick();                                  // e0+7
    chk("pre_rst_busy", 32'(busy_m), 32'd1);
    chk("pre_rst_din",  32'(din_m),  32'd3);
    reset_L = 1'b0;
    #1;
    chk_main_zero("rst_mid");
    repeat (3) tick();
    chk("rst_hold_done", 32'(done_m), 32'd0);
    chk("rst_hold_busy", 32'(busy_m), 32'd0);
    reset_L = 1'b1;
    tick();

    // stop on first error
    start_s = 1'b1; tick(); start_s = 1'b0;            // e0
    repeat (3) tick();                                  // e0+3
    chk("stop_e3_done", 32'(done_s), 32'd0);
    tick();                                             // e0+4
    chk("stop_done", 32'(done_s), 32'd1);
    chk("stop_pass", 32'(pass_s), 32'd0);
    chk("stop_busy", 32'(busy_s), 32'd0);
    chk("stop_cnt",  32'(cnt_s),  32'd1);
    chk("stop_fpat", 32'(fpat_s), 32'h1);
    chk("stop_fval", 32'(fval_s), 32'hF);

    // saturating 2-bit error counter
    start_t = 1'b1; tick(); start_t = 1'b0;            // e0
    repeat (4) tick();                                  // e0+4
    chk("sat_e4_cnt", 32'(cnt_t), 32'd2);
    repeat (4) tick();                                  // e0+8
    chk("sat_e8_cnt", 32'(cnt_t), 32'd3);
    repeat (24) tick();                                 // e0+32
    chk("sat_done", 32'(done_t), 32'd1);
    chk("sat_pass", 32'(pass_t), 32'd0);
    chk("sat_cnt",  32'(cnt_t),  32'd3);
    chk("sat_ev",   32'(ev_t),   32'd1);
    chk("sat_fpat", 32'(fpat_t), 32'h0);
    chk("sat_fval", 32'(fval_t), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/not_gate_bist_checker.md
# not_gate_bist_checker

Synthesizable, parametrised self-test engine for an N-bit inverter bank. It drives every input pattern onto the bank, waits a programmable settle time, and compares the bank output against the bitwise complement. It reports error count, first failure and pass/fail. It sits beside the inverter under test: `dut_in` feeds the bank input and the bank output returns on `dut_out`. The same block serves simulation benches and on-chip built-in self-test.

## Interface
- `WIDTH`, 4: bits of the inverter bank; exhaustive sweep covers 2^WIDTH patterns (1..16).
- `SETTLE`, 2: clock cycles each pattern is held before its compare (>= 1).
- `ERR_W`, 8: width of the saturating error counter.
- `STOP_ON_ERR`, 0: 1 ends the run at the first mismatch.

Ports:
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `reset_L`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request to begin a sweep.
- `abort`  input  1  ends a running sweep early.
- `dut_in`  output  WIDTH  pattern driven to the inverter bank.
- `dut_out`  input  WIDTH  inverter bank output.
- `busy`  output  1  sweep in progress.
- `done`  output  1  sweep finished; sticky until next accepted `start`.
- `pass`  output  1  valid when `done`; 1 = no mismatch and not aborted.
- `err_count`  output  ERR_W  mismatches seen, saturating at 2^ERR_W-1.
- `err_valid`  output  1  at least one mismatch captured.
- `first_err_pattern`  output  WIDTH  `dut_in` value at the first mismatch.
- `first_err_value`  output  WIDTH  `dut_out` value at the first mismatch.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE, and every output is 0.
- **Accepting start.** `start` is accepted only in IDLE or DONE, at edge e0. In that same edge:
  - `dut_in`<=0, the settle counter loads, and the block enters RUN with `busy`=1.
  - `done`, `pass`, `err_count`, `err_valid` and both first-error registers are cleared.
- **Start while busy.** `start` in RUN is ignored.
- **RUN compare.** Each pattern P is held SETTLE cycles. On the SETTLE-th edge after P was applied:
  - `dut_out` is compared with ~P (bitwise, WIDTH bits). X/Z on `dut_out` counts as a mismatch.
  - On mismatch, `err_count` increments and saturates at 2^ERR_W-1 (no wrap).
  - If `err_valid`=0, the block captures `first_err_pattern`=P and `first_err_value`=`dut_out`, and sets `err_valid`=1.
  - On the same edge, `dut_in`<=P+1, unless P is the last pattern (2^WIDTH-1).
- **Normal finish.** The last pattern's compare edge enters DONE: `busy`<=0, `done`<=1, and `pass`<=(no mismatch including this one).
- **STOP_ON_ERR=1.** The first mismatch edge enters DONE with `pass`=0. `err_count` is 1.
- **Abort.** `abort` in RUN enters DONE at that edge with `pass`=0.
  - If that edge is also a compare edge, the compare is still recorded.
  - `abort` in IDLE or DONE is ignored. `start` and `abort` together in IDLE/DONE: `start` wins.
- **dut_in after finishing.** `dut_in` holds the last applied pattern in DONE and IDLE until the next start.
- **Reset mid-run.** Asserting `reset_L` low mid-run immediately zeroes all outputs and returns to IDLE; no `done` pulse is produced.

## Timing
- Compares occur at edges e0+k·SETTLE for k=1..2^WIDTH.
- A full sweep takes 2^WIDTH·SETTLE cycles. `done` is high from edge e0+2^WIDTH·SETTLE.
- `dut_out` must settle within SETTLE-1 cycles plus combinational delay after `dut_in` changes.
- All outputs are registered; no combinational path from `dut_out` or `start`.
- Result outputs are stable while `done`=1.

## Test plan
- **Reset:** assert `reset_L`=0 mid-sweep at cycle 7 -> all outputs 0 asynchronously; state IDLE; no `done`.
- **Good inverter:** WIDTH=4, SETTLE=2, `dut_out`=~`dut_in` -> `done` at e0+32, `pass`=1, `err_count`=0, `err_valid`=0, `dut_in`=4'hF.
- **Stuck-at-1 on bit 0:**
  - STOP_ON_ERR=0 -> 8 mismatches, `err_count`=8, `first_err_pattern`=4'h1, `first_err_value`=4'hF, `pass`=0 at e0+32.
  - STOP_ON_ERR=1 -> `done` at e0+4, `err_count`=1.
- **Saturation:** ERR_W=2, `dut_out` tied 4'h0 -> 15 mismatches, `err_count`=3, `first_err_pattern`=4'h0, `first_err_value`=4'h0, `pass`=0.
- **Control:**
  - `start` pulsed at e0+6 while busy -> ignored; sweep still ends at e0+32.
  - `abort` at e0+5 -> `done`=1, `pass`=0, `busy`=0 on that edge.
  - New `start` from DONE -> all results clear on the accepting edge.
